// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the FIFO write port.
// The arbiter takes the slave side; the producer/FIFO environment takes the master side.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_full;
    logic                     fifo_write;
    logic [WIDTH-1:0]         fifo_data;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write, fifo_data, grant, busy
    );

    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_data, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bursts bounded to MAX_BURST words and full-flag backpressure.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              reset,
    fifo_wr_arbiter_if.slave bus
);
    localparam int LIDX = $clog2(NUM_REQ);
    localparam int BW   = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [LIDX-1:0]    r_last_idx;
    logic [BW-1:0]      r_burst_cnt;

    logic [WIDTH-1:0]   w_words [NUM_REQ];
    logic               w_found;
    logic [LIDX-1:0]    w_pick;
    logic               w_busy;
    logic               w_gvalid;
    logic               w_last_beat;
    logic [NUM_REQ-1:0] w_ready;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign w_words[i] = bus.req_data[i*WIDTH +: WIDTH];
    end

    // Search starts just past the last winner, so it drops to lowest priority.
    always_comb begin
        logic [LIDX-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = LIDX'((int'(r_last_idx) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    assign w_busy      = (r_state == GRANT);
    assign w_gvalid    = bus.req_valid[r_last_idx];
    assign w_last_beat = (r_burst_cnt == BW'(MAX_BURST - 1));
    assign w_ready     = (w_busy && !bus.fifo_full) ? r_grant : '0;

    assign bus.req_ready  = w_ready;
    assign bus.fifo_write = |(bus.req_valid & w_ready);
    assign bus.fifo_data  = w_busy ? w_words[r_last_idx] : '0;
    assign bus.grant      = r_grant;
    assign bus.busy       = w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last_idx  <= LIDX'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                        r_last_idx  <= w_pick;
                        r_burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    // A full FIFO only stalls; it never ends the burst.
                    if (!w_gvalid || (!bus.fifo_full && w_last_beat)) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_burst_cnt <= '0;
                    end else if (!bus.fifo_full) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single/all-requester bursts,
// full-flag stalls, early drop and mid-burst reset.
module tb_fifo_wr_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] cnt  [N];
    logic [7:0] base [N] = '{8'h00, 8'h10, 8'hA0, 8'h30};
    logic [7:0] wlog [$];

    fifo_wr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    fifo_wr_arbiter #(
        .WIDTH(W),
        .NUM_REQ(N),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic update_data();
        for (int i = 0; i < N; i++)
            bus.req_data[i*W +: W] = base[i] + cnt[i];
    endtask

    // Producers advance their word after each accepted handshake.
    task automatic step();
        logic [N-1:0] xfer;
        @(negedge clk);
        xfer = bus.req_valid & bus.req_ready;
        if (xfer != '0) wlog.push_back(bus.fifo_data);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (xfer[i]) cnt[i] = cnt[i] + 8'd1;
        update_data();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 8'h00;
        update_data();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wlog.delete();
    endtask

    initial begin
        logic [3:0] t2_g [7] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4};
        logic       t2_w [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] t2_d [7] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3,
                                 8'h00, 8'hA4};

        // Reset state
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 8'h00;
        update_data();
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_write", bus.fifo_write, 0);
        chk("rst_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // No requests for 10 cycles
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("idle_grant", bus.grant, 0);
            chk("idle_busy", bus.busy, 0);
            chk("idle_write", bus.fifo_write, 0);
            step();
        end

        // Requester 2 alone: burst of 4, bubble, regrant
        do_reset();
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            #1;
            chk($sformatf("r2_grant_c%0d", c), bus.grant, t2_g[c]);
            chk($sformatf("r2_write_c%0d", c), bus.fifo_write, t2_w[c]);
            chk($sformatf("r2_data_c%0d", c), bus.fifo_data, t2_d[c]);
            chk($sformatf("r2_busy_c%0d", c), bus.busy, t2_w[c]);
            step();
        end

        // All four requesters valid: round robin, 16 writes in 20 cycles
        do_reset();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 22; c++) begin
            int pos;
            int slot;
            int idx;
            logic [3:0] eg;
            logic [7:0] ed;
            logic       ew;
            pos  = c % 5;
            slot = c / 5;
            idx  = slot % 4;
            eg   = (pos == 0) ? 4'h0 : 4'(1 << idx);
            ew   = (pos != 0);
            ed   = (pos == 0) ? 8'h00
                 : 8'(base[idx] + 4 * (slot / 4) + pos - 1);
            #1;
            if (c == 20) chk("rr_wcount20", wlog.size(), 16);
            chk($sformatf("rr_grant_c%0d", c), bus.grant, eg);
            chk($sformatf("rr_write_c%0d", c), bus.fifo_write, ew);
            chk($sformatf("rr_data_c%0d", c), bus.fifo_data, ed);
            step();
        end
        for (int j = 0; j < 16; j++)
            chk($sformatf("rr_log%0d", j), wlog[j], 8'(base[j/4] + j%4));

        // Requester 1 stalled 3 cycles by fifo_full after its 2nd word
        do_reset();
        bus.req_valid = 4'b0010;
        #1;
        chk("st_bubble", bus.grant, 0);
        step();
        #1;
        chk("st_data0", bus.fifo_data, 8'h10);
        chk("st_write0", bus.fifo_write, 1);
        step();
        #1;
        chk("st_data1", bus.fifo_data, 8'h11);
        step();
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st_hold_grant%0d", c), bus.grant, 4'b0010);
            chk($sformatf("st_hold_ready%0d", c), bus.req_ready, 0);
            chk($sformatf("st_hold_write%0d", c), bus.fifo_write, 0);
            chk($sformatf("st_hold_busy%0d", c), bus.busy, 1);
            step();
        end
        bus.fifo_full = 1'b0;
        #1;
        chk("st_data2", bus.fifo_data, 8'h12);
        chk("st_write2", bus.fifo_write, 1);
        step();
        #1;
        chk("st_data3", bus.fifo_data, 8'h13);
        chk("st_write3", bus.fifo_write, 1);
        step();
        #1;
        chk("st_rel_grant", bus.grant, 0);
        chk("st_rel_write", bus.fifo_write, 0);
        chk("st_wcount", wlog.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("st_log%0d", j), wlog[j], 8'h10 + 8'(j));

        // Requester 1 drops after 2 words; requester 3 gets a full burst
        do_reset();
        bus.req_valid = 4'b1010;
        #1;
        chk("dr_bubble", bus.grant, 0);
        step();
        #1;
        chk("dr_grant1", bus.grant, 4'b0010);
        chk("dr_data0", bus.fifo_data, 8'h10);
        step();
        #1;
        chk("dr_data1", bus.fifo_data, 8'h11);
        step();
        bus.req_valid = 4'b1000;
        #1;
        chk("dr_drop_grant", bus.grant, 4'b0010);
        chk("dr_drop_write", bus.fifo_write, 0);
        step();
        #1;
        chk("dr_bubble2", bus.grant, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("dr_g3_grant%0d", k), bus.grant, 4'b1000);
            chk($sformatf("dr_g3_write%0d", k), bus.fifo_write, 1);
            chk($sformatf("dr_g3_data%0d", k), bus.fifo_data, 8'h30 + 8'(k));
            step();
        end
        #1;
        chk("dr_g3_rel", bus.grant, 0);

        // Reset between edges during requester 3's 2nd word
        do_reset();
        bus.req_valid = 4'b1000;
        #1;
        chk("mr_bubble", bus.grant, 0);
        step();
        #1;
        chk("mr_grant", bus.grant, 4'b1000);
        chk("mr_data0", bus.fifo_data, 8'h30);
        step();
        #1;
        chk("mr_write1", bus.fifo_write, 1);
        chk("mr_data1", bus.fifo_data, 8'h31);
        reset = 1'b1;
        #1;
        chk("mr_async_grant", bus.grant, 0);
        chk("mr_async_write", bus.fifo_write, 0);
        chk("mr_async_busy", bus.busy, 0);
        chk("mr_async_ready", bus.req_ready, 0);
        step();
        reset         = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("mr_wcount", wlog.size(), 1);
        chk("mr_log0", wlog[0], 8'h30);
        chk("mr_post_bubble", bus.grant, 0);
        step();
        #1;
        chk("mr_first_grant", bus.grant, 4'b0001);
        chk("mr_first_data", bus.fifo_data, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
